uart_rx_core: RTL and testbench

- 8N1 UART receiver for the `uart_rx` pin; the counterpart of the bench/host transmitter driving that line.
- Runs at 9600 bps from the 12 MHz board clock.
- Synchronises the pin, rejects short low glitches, samples each bit at mid-bit, and presents each byte on a valid/ready holding register.
- Sits between the top-level `uart_rx` pin and the command/LED logic in `top`.

---
 rtl/uart_rx_core_pkg.sv | 11 +
 rtl/sync_2ff.sv | 14 +
 rtl/uart_rx_core.sv | 132 +++++++++++++
 tb/tb_uart_rx_core.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_core_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;
  localparam int DATA_BITS    = 8;
  localparam int DEFAULT_BAUD = 9600;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an idle-high async pin; both stages reset to 1.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) {q, meta} <= 2'b11;
    else     {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each sample point.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 12_000_000,
  parameter int BAUD   = DEFAULT_BAUD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int TW           = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 8) begin : g_bad_rate
      $error("uart_rx_core: CLKS_PER_BIT must be >= 8");
    end
  endgenerate

  logic                 rxs;
  state_t               state;
  logic [TW-1:0]        timer;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 sampling, at_t, decide, sample;

  sync_2ff u_sync (.clk(clk), .rst(rst), .d(uart_rx), .q(rxs));

  assign sampling = (state == START) || (state == DATA) || (state == STOP);
  assign at_t     = (state == START) ? (timer == T_HALF) : (timer == T_FULL);

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one clock after T; the timer has already wrapped at T,
  // so bit timing never drifts.
  logic [1:0] hist;
  logic       pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= 2'b11;
      pend <= 1'b0;
    end else begin
      hist <= {hist[0], rxs};
      pend <= sampling && at_t;
    end
  end

  assign decide = pend;
  assign sample = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  assign decide = sampling && at_t;
  assign sample = rxs;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
      if (sampling) timer <= at_t ? '0 : timer + 1'b1;

      case (state)
        IDLE: if (!rxs) begin
          state <= START;
          timer <= '0;
          busy  <= 1'b1;
        end
        START: if (decide) begin
          if (!sample) begin
            state   <= DATA;
            bit_idx <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: if (decide) begin
          shreg <= {sample, shreg[DATA_BITS-1:1]};
          if (bit_idx == 3'd7) state <= STOP;
          else                 bit_idx <= bit_idx + 3'd1;
        end
        STOP: if (decide) begin
          if (sample) begin
            state <= IDLE;
            busy  <= 1'b0;
            // A same-cycle accept frees the register, so the new byte wins.
            if (!rx_valid || rx_ready) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end
        end
        BREAK: if (rxs) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit.
module tb_uart_rx_core;
  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] EXP_SPIKE = 8'h96;
`else
  localparam logic [7:0] EXP_SPIKE = 8'h69;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int n_chk = 0;
  int n_pass = 0;
  int ferr_cnt = 0;
  logic [7:0] rxq[$];

  uart_rx_core #(.CLK_HZ(153_600), .BAUD(9600)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) rxq.push_back(rx_data);
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit, LSB-first data, stop bit; optional 1-clock inversion mid data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit spike);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < C; c++) begin
        @(posedge clk);
        #1 uart_rx = bits[i] ^ (spike && i >= 1 && i <= 8 && c == H);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit seen;
    tick(5);
    @(negedge clk);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(4);

    // short low glitch
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    chk("glitch_busy_hi", seen, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = !busy;
    end
    chk("glitch_busy_lo", seen, 1'b1);
    tick(50);
    chk("glitch_valid", rx_valid, 1'b0);
    chk("glitch_ferr", ferr_cnt, 0);
    chk("glitch_ovr", overrun, 1'b0);
    chk("glitch_q", rxq.size(), 0);

    // two back-to-back bytes
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    tick(20);
    chk("byte_cnt", rxq.size(), 2);
    chk("byte0", rxq[0], 8'h55);
    chk("byte1", rxq[1], 8'hA3);
    chk("byte_ferr", ferr_cnt, 0);

    // framing error followed by a held break
    n0 = rxq.size();
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(2 * C);
    uart_rx = 1'b1;
    tick(C);
    chk("frm_ferr", ferr_cnt, 1);
    chk("frm_q", rxq.size(), n0);
    chk("frm_valid", rx_valid, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    tick(20);
    chk("frm_next_cnt", rxq.size(), n0 + 1);
    chk("frm_next", rxq[$], 8'h01);
    chk("frm_ferr2", ferr_cnt, 1);

    // overrun
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(20);
    @(negedge clk);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    chk("ovr_acc_valid", rx_valid, 1'b0);
    chk("ovr_acc_flag", overrun, 1'b0);
    tick(2);
    rx_ready = 1'b1;

    // reset mid-way through bit 4 of 0xFF
    uart_rx = 1'b0;
    tick(C);
    uart_rx = 1'b1;
    tick(4 * C + H);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", rx_valid, 1'b0);
    chk("post_rst_data", rx_data, 8'h00);
    chk("post_rst_ovr", overrun, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    tick(2 * C);
    n0 = rxq.size();
    send_frame(8'h7E, 1'b1, 1'b0);
    tick(20);
    chk("rst_next_cnt", rxq.size(), n0 + 1);
    chk("rst_next", rxq[$], 8'h7E);

    // centre-of-bit spikes
    n0 = rxq.size();
    send_frame(8'h96, 1'b1, 1'b1);
    tick(20);
    chk("spike_cnt", rxq.size(), n0 + 1);
    chk("spike_byte", rxq[$], EXP_SPIKE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
